audio_ram_sequencer: RTL and testbench
======================================

AUDIO_RAM_SEQUENCER -- requirements
Module: audio_ram_sequencer

Interface
REQ-001 Parameter SAMPLE_W, default 16, audio sample and RAM data width in bits.
REQ-002 Parameter ADDR_W, default 26, RAM word address width.
REQ-003 Parameter SLOTS, default 4, number of independent clips (power of two, 1..16).
REQ-004 Parameter SLOT_LOG2, default 20, log2 of samples per slot; SLOTS*2^SLOT_LOG2 SHALL NOT exceed 2^ADDR_W.
REQ-005 clk  in  1  system clock.
REQ-006 pb_reset  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  one-cycle command strobe.
REQ-008 cmd  in  3  command code: 0 PLAY, 1 RECORD, 2 DELETE, 3 PAUSE, 4 DELETE_ALL, 5 STOP; 6 and 7 are ignored.
REQ-009 cmd_slot  in  log2(SLOTS) (minimum 1)  target slot for PLAY, RECORD and DELETE.
REQ-010 loop_en  in  1  when high, playback wraps to the slot start at the recorded end.
REQ-011 sample_tick  in  1  one-cycle pulse per audio frame.
REQ-012 adc_sample  in  SAMPLE_W  capture sample, valid on sample_tick.
REQ-013 dac_sample  out  SAMPLE_W  registered playback sample.
REQ-014 ram_rdy  in  1  RAM accepts a request this cycle.
REQ-015 ram_addr  out  ADDR_W  RAM word address.
REQ-016 ram_wdata  out  SAMPLE_W  write data.
REQ-017 ram_we  out  1  one-cycle write request.
REQ-018 ram_rd_req  out  1  one-cycle read request.
REQ-019 ram_rd_valid  in  1  read data present.
REQ-020 ram_rdata  in  SAMPLE_W  read data.
REQ-021 ram_rd_ack  out  1  one-cycle read acknowledge.
REQ-022 status  out  8  {overrun, slot_full, paused, busy, state[3:0]}.

Function
REQ-023 The sequencer SHALL use the states IDLE=0, REC_WAIT=1, REC_WRITE=2, PLAY_WAIT=3, PLAY_REQ=4, PLAY_DATA=5, PAUSED=6 and CLEAR=7.
REQ-024 Address SHALL be computed as slot*2^SLOT_LOG2 + ptr, zero-extended to ADDR_W.
REQ-025 Each slot SHALL keep a length register of SLOT_LOG2+1 bits, holding 0..2^SLOT_LOG2.
REQ-026 In IDLE, RECORD SHALL clear ptr, clear the slot length and go to REC_WAIT.
REQ-027 In IDLE, PLAY to a slot with nonzero length SHALL clear ptr and go to PLAY_WAIT.
REQ-028 PLAY to an empty slot SHALL be ignored.
REQ-029 In REC_WAIT, sample_tick SHALL latch adc_sample into ram_wdata and go to REC_WRITE.
REQ-030 In REC_WRITE, ram_we SHALL be asserted for exactly the first cycle in which ram_rdy is high; ptr and length SHALL then increment and the FSM SHALL return to REC_WAIT.
REQ-031 When length reaches 2^SLOT_LOG2, the sequencer SHALL set slot_full, return to IDLE and perform no further write.
REQ-032 In PLAY_WAIT, sample_tick SHALL go to PLAY_REQ.
REQ-033 In PLAY_REQ, ram_rd_req SHALL be asserted for the single cycle in which ram_rdy is high, then the FSM SHALL go to PLAY_DATA.
REQ-034 In PLAY_DATA, on ram_rd_valid the sequencer SHALL load dac_sample from ram_rdata, pulse ram_rd_ack for that same cycle and increment ptr.
REQ-035 After that read, the FSM SHALL go to PLAY_WAIT, or, if ptr equals length, wrap ptr to 0 (loop_en=1) or return to IDLE (loop_en=0).
REQ-036 A sample_tick arriving in REC_WRITE, PLAY_REQ or PLAY_DATA SHALL set sticky overrun; that sample SHALL be dropped and the FSM SHALL NOT stall.
REQ-037 PAUSE in any REC_* or PLAY_* state SHALL take effect at the next WAIT state, entering PAUSED with ptr held; a pending RAM transaction SHALL always complete first.
REQ-038 In PAUSED, PAUSE SHALL resume into the originating WAIT state.
REQ-039 In PAUSED, STOP SHALL go to IDLE.
REQ-040 STOP in any non-IDLE state SHALL go to IDLE after the pending RAM transaction completes; the recorded length SHALL be kept.
REQ-041 DELETE in IDLE or PAUSED SHALL zero the target slot length; deleting the active slot while PAUSED SHALL go to IDLE.
REQ-042 DELETE_ALL from IDLE or PAUSED SHALL enter CLEAR and zero one slot per cycle (SLOTS cycles), then go to IDLE.
REQ-043 During CLEAR, busy SHALL be 1 and commands SHALL be ignored.
REQ-044 Commands not listed for the current state SHALL be ignored.
REQ-045 A new RECORD or PLAY SHALL clear overrun and slot_full.
REQ-046 busy SHALL be 1 in every state except IDLE and PAUSED.

Reset
REQ-047 pb_reset SHALL force IDLE, ptr=0, all lengths=0, and dac_sample, ram_wdata and ram_addr to 0.
REQ-048 pb_reset SHALL force ram_we, ram_rd_req and ram_rd_ack to 0 and clear overrun, slot_full and paused.
REQ-049 Reset mid-transaction SHALL abandon the transaction without asserting any further strobe.

Verification
REQ-050 SLOT_LOG2=3: RECORD slot 1, 8 ticks with samples 0x0101..0x0108 -> 8 writes at addresses 8..15, then slot_full=1 and state IDLE.
REQ-051 PLAY slot 1, loop_en=0, ram_rdy=1 -> dac_sample steps 0x0101..0x0108, each read acked once, then IDLE.
REQ-052 PLAY with loop_en=1, 10 ticks -> the ninth sample read is from address 8 (value 0x0101).
REQ-053 Hold ram_rdy=0 for 3 ticks during REC_WRITE -> overrun=1, exactly one write issued once ram_rdy rises.
REQ-054 PAUSE at ptr=3, then PAUSE again -> playback resumes at address base+3.
REQ-055 PAUSE at ptr=3, then STOP -> IDLE.
REQ-056 DELETE_ALL -> busy for SLOTS cycles, all lengths 0, and a following PLAY is ignored.

Source files
------------

// File: rtl/audio_ram_sequencer_if.sv
// RAM-side bus of the audio sequencer: request strobes toward the memory, read data back.
// Handshake: a write or read request fires only in a cycle where ram_rdy is high; read data is held by the RAM while ram_rd_valid is high and is consumed in the cycle where ram_rd_ack is high.
interface audio_ram_sequencer_if #(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 26
) ();
  logic                ram_rdy;
  logic [ADDR_W-1:0]   ram_addr;
  logic [SAMPLE_W-1:0] ram_wdata;
  logic                ram_we;
  logic                ram_rd_req;
  logic                ram_rd_valid;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic                ram_rd_ack;

  modport master (
    input  ram_rdy, ram_rd_valid, ram_rdata,
    output ram_addr, ram_wdata, ram_we, ram_rd_req, ram_rd_ack
  );

  modport slave (
    output ram_rdy, ram_rd_valid, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_rd_req, ram_rd_ack
  );
endinterface

// File: rtl/audio_ram_sequencer.sv
// Multi-slot audio clip recorder/player: one RAM word per sample, each slot owns a
// fixed 2^SLOT_LOG2-word region and a length register. State is visible in status[3:0].
module audio_ram_sequencer #(
  parameter int SAMPLE_W  = 16,
  parameter int ADDR_W    = 26,
  parameter int SLOTS     = 4,
  parameter int SLOT_LOG2 = 20,
  localparam int SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                clk,
  input  logic                pb_reset,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd,
  input  logic [SLOT_W-1:0]   cmd_slot,
  input  logic                loop_en,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] adc_sample,
  output logic [SAMPLE_W-1:0] dac_sample,
  output logic [7:0]          status,
  audio_ram_sequencer_if.master ram
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_REC_WAIT  = 4'd1,
    ST_REC_WRITE = 4'd2,
    ST_PLAY_WAIT = 4'd3,
    ST_PLAY_REQ  = 4'd4,
    ST_PLAY_DATA = 4'd5,
    ST_PAUSED    = 4'd6,
    ST_CLEAR     = 4'd7
  } state_t;

  localparam logic [2:0] CMD_PLAY    = 3'd0;
  localparam logic [2:0] CMD_RECORD  = 3'd1;
  localparam logic [2:0] CMD_DELETE  = 3'd2;
  localparam logic [2:0] CMD_PAUSE   = 3'd3;
  localparam logic [2:0] CMD_DEL_ALL = 3'd4;
  localparam logic [2:0] CMD_STOP    = 3'd5;

  localparam logic [SLOT_LOG2:0] FULL_LEN = {1'b1, {SLOT_LOG2{1'b0}}};
  localparam logic [SLOT_LOG2:0] ONE_LEN  = 1;
  localparam logic [SLOT_W-1:0]  ONE_SLOT = 1;
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(SLOTS - 1);

  state_t               state, state_next;
  logic [SLOT_LOG2:0]   len_q [SLOTS];
  logic [SLOT_LOG2:0]   ptr;
  logic [SLOT_W-1:0]    act_slot;
  logic [SLOT_W-1:0]    clr_idx;
  logic                 overrun, slot_full;
  logic                 pause_pend, stop_pend, ret_rec;
  logic                 busy, in_xfer;

  logic [SLOT_W-1:0]    cmd_idx;
  logic [SLOT_LOG2:0]   act_len, cmd_len, ptr_inc, len_inc;
  logic [ADDR_W-1:0]    addr_calc;
  logic                 pause_now, stop_now;

  assign cmd_idx   = (SLOTS == 1) ? '0 : cmd_slot;
  assign act_len   = len_q[act_slot];
  assign cmd_len   = len_q[cmd_idx];
  assign ptr_inc   = ptr + ONE_LEN;
  assign len_inc   = act_len + ONE_LEN;
  assign addr_calc = (ADDR_W'(act_slot) << SLOT_LOG2) | ADDR_W'(ptr[SLOT_LOG2-1:0]);
  // A PAUSE/STOP seen during a RAM transaction is remembered until it can act.
  assign pause_now = pause_pend | (cmd_valid && cmd == CMD_PAUSE);
  assign stop_now  = stop_pend  | (cmd_valid && cmd == CMD_STOP);

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_RECORD:  state_next = ST_REC_WAIT;
            CMD_PLAY:    if (cmd_len != '0) state_next = ST_PLAY_WAIT;
            CMD_DEL_ALL: state_next = ST_CLEAR;
            default:     state_next = ST_IDLE;
          endcase
        end
      end
      ST_REC_WAIT: begin
        if (stop_now)         state_next = ST_IDLE;
        else if (pause_now)   state_next = ST_PAUSED;
        else if (sample_tick) state_next = ST_REC_WRITE;
      end
      ST_REC_WRITE: begin
        if (ram.ram_rdy)
          state_next = (len_inc == FULL_LEN || stop_now) ? ST_IDLE : ST_REC_WAIT;
      end
      ST_PLAY_WAIT: begin
        if (stop_now)         state_next = ST_IDLE;
        else if (pause_now)   state_next = ST_PAUSED;
        else if (sample_tick) state_next = ST_PLAY_REQ;
      end
      ST_PLAY_REQ: begin
        if (ram.ram_rdy) state_next = ST_PLAY_DATA;
      end
      ST_PLAY_DATA: begin
        if (ram.ram_rd_valid) begin
          if (stop_now)                         state_next = ST_IDLE;
          else if (ptr_inc == act_len && !loop_en) state_next = ST_IDLE;
          else                                  state_next = ST_PLAY_WAIT;
        end
      end
      ST_PAUSED: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_PAUSE:   state_next = ret_rec ? ST_REC_WAIT : ST_PLAY_WAIT;
            CMD_STOP:    state_next = ST_IDLE;
            CMD_DELETE:  if (cmd_idx == act_slot) state_next = ST_IDLE;
            CMD_DEL_ALL: state_next = ST_CLEAR;
            default:     state_next = ST_PAUSED;
          endcase
        end
      end
      ST_CLEAR: begin
        if (clr_idx == LAST_SLOT) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ram.ram_we     = (state == ST_REC_WRITE) && ram.ram_rdy;
    ram.ram_rd_req = (state == ST_PLAY_REQ)  && ram.ram_rdy;
    ram.ram_rd_ack = (state == ST_PLAY_DATA) && ram.ram_rd_valid;
    busy           = (state != ST_IDLE) && (state != ST_PAUSED);
    in_xfer        = (state == ST_REC_WRITE) || (state == ST_PLAY_REQ) ||
                     (state == ST_PLAY_DATA);
  end

  assign status = {overrun, slot_full, state == ST_PAUSED, busy, state};

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      for (int i = 0; i < SLOTS; i++) len_q[i] <= '0;
      ptr           <= '0;
      act_slot      <= '0;
      clr_idx       <= '0;
      overrun       <= 1'b0;
      slot_full     <= 1'b0;
      pause_pend    <= 1'b0;
      stop_pend     <= 1'b0;
      ret_rec       <= 1'b0;
      dac_sample    <= '0;
      ram.ram_wdata <= '0;
      ram.ram_addr  <= '0;
    end else begin
      if (in_xfer && sample_tick) overrun <= 1'b1;

      if (state_next == ST_IDLE || state_next == ST_PAUSED) begin
        pause_pend <= 1'b0;
        stop_pend  <= 1'b0;
      end else if (cmd_valid && in_xfer) begin
        if (cmd == CMD_PAUSE) pause_pend <= 1'b1;
        if (cmd == CMD_STOP)  stop_pend  <= 1'b1;
      end

      if (state_next == ST_PAUSED && state != ST_PAUSED)
        ret_rec <= (state == ST_REC_WAIT);

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd)
              CMD_RECORD: begin
                act_slot       <= cmd_idx;
                ptr            <= '0;
                len_q[cmd_idx] <= '0;
                overrun        <= 1'b0;
                slot_full      <= 1'b0;
              end
              CMD_PLAY: begin
                if (cmd_len != '0) begin
                  act_slot  <= cmd_idx;
                  ptr       <= '0;
                  overrun   <= 1'b0;
                  slot_full <= 1'b0;
                end
              end
              CMD_DELETE:  len_q[cmd_idx] <= '0;
              CMD_DEL_ALL: clr_idx <= '0;
              default: ;
            endcase
          end
        end
        ST_REC_WAIT: begin
          if (state_next == ST_REC_WRITE) begin
            ram.ram_wdata <= adc_sample;
            ram.ram_addr  <= addr_calc;
          end
        end
        ST_REC_WRITE: begin
          if (ram.ram_rdy) begin
            ptr             <= ptr_inc;
            len_q[act_slot] <= len_inc;
            if (len_inc == FULL_LEN) slot_full <= 1'b1;
          end
        end
        ST_PLAY_WAIT: begin
          if (state_next == ST_PLAY_REQ) ram.ram_addr <= addr_calc;
        end
        ST_PLAY_DATA: begin
          if (ram.ram_rd_valid) begin
            dac_sample <= ram.ram_rdata;
            if (ptr_inc == act_len && loop_en && !stop_now) ptr <= '0;
            else                                           ptr <= ptr_inc;
          end
        end
        ST_PAUSED: begin
          if (cmd_valid && cmd == CMD_DELETE)  len_q[cmd_idx] <= '0;
          if (cmd_valid && cmd == CMD_DEL_ALL) clr_idx <= '0;
        end
        ST_CLEAR: begin
          len_q[clr_idx] <= '0;
          clr_idx        <= clr_idx + ONE_SLOT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_ram_sequencer.sv
// Directed bench for audio_ram_sequencer with 8-sample slots and a small behavioural RAM.
// Expected RAM writes sit in exp_q; reads and acks are logged by a monitor.
module tb_audio_ram_sequencer;
  localparam int SW = 16;
  localparam int AW = 26;
  localparam int NS = 4;
  localparam int SL = 3;

  logic          clk = 1'b0;
  logic          pb_reset;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [1:0]    cmd_slot;
  logic          loop_en;
  logic          sample_tick;
  logic [SW-1:0] adc_sample;
  logic [SW-1:0] dac_sample;
  logic [7:0]    status;

  audio_ram_sequencer_if #(.SAMPLE_W(SW), .ADDR_W(AW)) ram_bus ();

  audio_ram_sequencer #(.SAMPLE_W(SW), .ADDR_W(AW), .SLOTS(NS), .SLOT_LOG2(SL)) dut (
    .clk         (clk),
    .pb_reset    (pb_reset),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_slot    (cmd_slot),
    .loop_en     (loop_en),
    .sample_tick (sample_tick),
    .adc_sample  (adc_sample),
    .dac_sample  (dac_sample),
    .status      (status),
    .ram         (ram_bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural RAM: read data appears the cycle after the request and holds until acked
  logic [SW-1:0] mem [64];
  always @(posedge clk) begin
    if (pb_reset) begin
      ram_bus.ram_rd_valid <= 1'b0;
      ram_bus.ram_rdata    <= '0;
    end else begin
      if (ram_bus.ram_we) mem[ram_bus.ram_addr[5:0]] <= ram_bus.ram_wdata;
      if (ram_bus.ram_rd_valid && ram_bus.ram_rd_ack) ram_bus.ram_rd_valid <= 1'b0;
      if (ram_bus.ram_rd_req) begin
        ram_bus.ram_rd_valid <= 1'b1;
        ram_bus.ram_rdata    <= mem[ram_bus.ram_addr[5:0]];
      end
    end
  end

  // scoreboard
  logic [AW+SW-1:0] exp_q [$];
  logic [AW-1:0]    rd_log [$];
  int               wr_count  = 0;
  int               ack_count = 0;
  int               n_checks  = 0;
  int               n_fail    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!pb_reset) begin
      if (ram_bus.ram_we) begin
        logic [AW+SW-1:0] e;
        wr_count++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(ram_bus.ram_addr), 64'(e[AW+SW-1:SW]));
          check("wr_data", 64'(ram_bus.ram_wdata), 64'(e[SW-1:0]));
        end
      end
      if (ram_bus.ram_rd_req) rd_log.push_back(ram_bus.ram_addr);
      if (ram_bus.ram_rd_ack) ack_count++;
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [1:0] s);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_slot  = s;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_tick(input logic [SW-1:0] smp);
    sample_tick = 1'b1;
    adc_sample  = smp;
    cyc(1);
    sample_tick = 1'b0;
    cyc(3);
  endtask

  function automatic logic [AW+SW-1:0] wr_entry(input int addr, input int data);
    return {AW'(addr), SW'(data)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    pb_reset = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_slot = '0;
    loop_en = 1'b0; sample_tick = 1'b0; adc_sample = '0; ram_bus.ram_rdy = 1'b1;
    cyc(3);
    check("rst_status", 64'(status), 64'h00);
    check("rst_dac", 64'(dac_sample), 64'h0);
    check("rst_addr", 64'(ram_bus.ram_addr), 64'h0);
    check("rst_wdata", 64'(ram_bus.ram_wdata), 64'h0);
    check("rst_strobes", 64'({ram_bus.ram_we, ram_bus.ram_rd_req, ram_bus.ram_rd_ack}), 64'h0);
    pb_reset = 1'b0;
    cyc(1);

    // record slot 1 to full
    send_cmd(3'd1, 2'd1);
    check("rec_start_status", 64'(status), 64'h11);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(wr_entry(8 + i - 1, 16'h0100 + i));
      do_tick(SW'(16'h0100 + i));
      if (i == 7) check("rec_wait_status", 64'(status), 64'h11);
    end
    check("rec_full_status", 64'(status), 64'h40);
    check("rec_wr_count", 64'(wr_count), 64'd8);
    check("rec_exp_empty", 64'(exp_q.size()), 64'd0);
    do_tick(16'hdead);
    check("no_wr_after_full", 64'(wr_count), 64'd8);

    // single-shot playback
    rd_log.delete(); ack_count = 0; loop_en = 1'b0;
    send_cmd(3'd0, 2'd1);
    check("play_start_status", 64'(status), 64'h13);
    for (int i = 1; i <= 8; i++) begin
      do_tick('0);
      check($sformatf("play_dac_%0d", i), 64'(dac_sample), 64'(16'h0100 + i));
    end
    check("play_end_status", 64'(status), 64'h00);
    check("play_ack_count", 64'(ack_count), 64'd8);
    check("play_rd_count", 64'(rd_log.size()), 64'd8);
    check("play_rd_first", 64'(rd_log[0]), 64'd8);
    check("play_rd_last", 64'(rd_log[7]), 64'd15);

    // looped playback
    rd_log.delete(); loop_en = 1'b1;
    send_cmd(3'd0, 2'd1);
    for (int i = 1; i <= 10; i++) begin
      do_tick('0);
      if (i == 9) begin
        check("loop_dac9", 64'(dac_sample), 64'h0101);
        check("loop_rd9_addr", 64'(rd_log[8]), 64'd8);
      end
    end
    check("loop_dac10", 64'(dac_sample), 64'h0102);
    send_cmd(3'd5, 2'd0);
    check("loop_stop_status", 64'(status), 64'h00);
    loop_en = 1'b0;

    // write stall with overrun
    ram_bus.ram_rdy = 1'b0;
    send_cmd(3'd1, 2'd2);
    exp_q.push_back(wr_entry(16, 16'h0201));
    do_tick(16'h0201);
    check("rec_stall_status", 64'(status), 64'h12);
    repeat (3) do_tick(16'h0bad);
    check("stall_no_wr", 64'(wr_count), 64'd8);
    check("overrun_status", 64'(status), 64'h92);
    ram_bus.ram_rdy = 1'b1;
    cyc(3);
    check("stall_one_wr", 64'(wr_count), 64'd9);
    check("stall_resume_status", 64'(status), 64'h91);
    check("stall_exp_empty", 64'(exp_q.size()), 64'd0);
    send_cmd(3'd5, 2'd0);
    check("overrun_sticky", 64'(status), 64'h80);

    // pause at ptr 3, resume
    rd_log.delete();
    send_cmd(3'd0, 2'd1);
    check("play2_status", 64'(status), 64'h13);
    repeat (3) do_tick('0);
    check("pause_dac", 64'(dac_sample), 64'h0103);
    send_cmd(3'd3, 2'd0);
    check("paused_status", 64'(status), 64'h26);
    do_tick('0);
    check("paused_no_rd", 64'(rd_log.size()), 64'd3);
    send_cmd(3'd3, 2'd0);
    check("resume_status", 64'(status), 64'h13);
    do_tick('0);
    check("resume_addr", 64'(rd_log[3]), 64'd11);
    check("resume_dac", 64'(dac_sample), 64'h0104);
    send_cmd(3'd5, 2'd0);

    // pause at ptr 3, stop
    send_cmd(3'd0, 2'd1);
    repeat (3) do_tick('0);
    send_cmd(3'd3, 2'd0);
    send_cmd(3'd5, 2'd0);
    check("pause_stop_status", 64'(status), 64'h00);

    // reset during a stalled write
    ram_bus.ram_rdy = 1'b0;
    send_cmd(3'd1, 2'd3);
    do_tick(16'h0301);
    check("pre_rst_status", 64'(status), 64'h12);
    pb_reset = 1'b1;
    cyc(1);
    ram_bus.ram_rdy = 1'b1;
    cyc(2);
    pb_reset = 1'b0;
    cyc(2);
    check("midrst_status", 64'(status), 64'h00);
    check("midrst_wr_count", 64'(wr_count), 64'd9);
    check("midrst_dac", 64'(dac_sample), 64'h0);
    send_cmd(3'd0, 2'd1);
    check("play_after_rst_ignored", 64'(status), 64'h00);

    // delete one slot, keep another
    send_cmd(3'd1, 2'd1);
    exp_q.push_back(wr_entry(8, 16'h0aa1));
    exp_q.push_back(wr_entry(9, 16'h0aa2));
    do_tick(16'h0aa1);
    do_tick(16'h0aa2);
    send_cmd(3'd5, 2'd0);
    send_cmd(3'd1, 2'd0);
    exp_q.push_back(wr_entry(0, 16'h0c01));
    do_tick(16'h0c01);
    send_cmd(3'd5, 2'd0);
    check("rerec_wr_count", 64'(wr_count), 64'd12);
    send_cmd(3'd2, 2'd0);
    send_cmd(3'd0, 2'd0);
    check("play_deleted_ignored", 64'(status), 64'h00);
    send_cmd(3'd0, 2'd1);
    check("play_kept_len", 64'(status), 64'h13);
    send_cmd(3'd5, 2'd0);

    // delete all
    send_cmd(3'd4, 2'd0);
    check("clear_status", 64'(status), 64'h17);
    n = 0;
    while (status[4] && n < 20) begin
      n++;
      cyc(1);
    end
    check("clear_busy_cycles", 64'(n), 64'(NS));
    check("clear_end_status", 64'(status), 64'h00);
    send_cmd(3'd0, 2'd1);
    check("play_after_clear_s1", 64'(status), 64'h00);
    send_cmd(3'd0, 2'd2);
    check("play_after_clear_s2", 64'(status), 64'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
